// File: rtl/lc3b_mem_responder.sv
// Single-ported backing store serving an LC-3b instruction-fetch port (IF,
// read-only) and a data port (MEM, read/write) one access at a time, with a
// fixed, parameterised latency between acceptance and the response pulse.
module lc3b_mem_responder #(
  parameter int unsigned LATENCY    = 2,  // cycles from acceptance to resp, 1..15
  parameter int unsigned WORDS_LOG2 = 8   // log2 of store depth in 16-bit words
) (
  input  logic        clk,
  input  logic        rst,
  // Instruction-fetch port
  input  logic [15:0] if_memaddr,
  input  logic        if_memread,
  input  logic [1:0]  if_mem_byte_enable,
  output logic        if_mem_resp,
  output logic [15:0] if_mem_rdata,
  // Data port
  input  logic [15:0] mem_memaddr,
  input  logic        mem_memread,
  input  logic        mem_memwrite,
  input  logic [1:0]  mem_mem_byte_enable,
  input  logic [15:0] mem_mem_wdata,
  output logic        mem_mem_resp,
  output logic [15:0] mem_mem_rdata
);

  localparam int unsigned DEPTH    = 1 << WORDS_LOG2;
  localparam logic [3:0]  CNT_LOAD = 4'(LATENCY - 1);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_e;

  // Backing store
  logic [15:0] store [DEPTH];

  // FSM and captured request
  state_e                  state_q;
  logic [3:0]              cnt_q;
  logic                    port_mem_q;   // 1: MEM port owns the access, 0: IF port
  logic                    is_write_q;
  logic [WORDS_LOG2-1:0]   idx_q;
  logic [15:0]             wdata_q;
  logic [1:0]              be_q;
  logic [15:0]             rword_q;      // store word sampled at acceptance

  // Registered outputs
  logic        if_resp_q, mem_resp_q;
  logic [15:0] if_rdata_q, mem_rdata_q;

  // Arbitration result for the current IDLE cycle
  logic                  sel_valid;
  logic                  sel_mem;
  logic                  sel_write;
  logic [15:0]           sel_addr;
  logic [WORDS_LOG2-1:0] sel_idx;
  logic [15:0]           sel_rword;

  // Byte enables on the IF port and the address bits above the store index
  // carry no meaning here; the folded signal keeps them visibly consumed.
  logic unused_bits;
  assign unused_bits = ^{if_mem_byte_enable, if_memaddr, mem_memaddr};

  // Fixed-priority arbitration: the MEM port wins when both ports request.
  // NOTE: every signal written here gets a default first so no latch is inferred.
  always_comb begin
    sel_valid = 1'b0;
    sel_mem   = 1'b0;
    sel_write = 1'b0;
    sel_addr  = if_memaddr;
    if (mem_memread || mem_memwrite) begin
      sel_valid = 1'b1;
      sel_mem   = 1'b1;
      sel_write = mem_memwrite;   // read+write together is treated as a write
      sel_addr  = mem_memaddr;
    end else if (if_memread) begin
      sel_valid = 1'b1;
    end
  end

  assign sel_idx   = sel_addr[WORDS_LOG2:1];
  assign sel_rword = store[sel_idx];

  // Access sequencer: IDLE accepts, BUSY counts down, RESP pulses one port.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values and simulation matches the synthesised flops.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= 4'd0;
      port_mem_q  <= 1'b0;
      is_write_q  <= 1'b0;
      idx_q       <= '0;
      wdata_q     <= 16'h0000;
      be_q        <= 2'b00;
      rword_q     <= 16'h0000;
      if_resp_q   <= 1'b0;
      mem_resp_q  <= 1'b0;
      if_rdata_q  <= 16'h0000;
      mem_rdata_q <= 16'h0000;
    end else begin
      if_resp_q  <= 1'b0;
      mem_resp_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (sel_valid) begin
            port_mem_q <= sel_mem;
            is_write_q <= sel_write;
            idx_q      <= sel_idx;
            wdata_q    <= mem_mem_wdata;
            be_q       <= mem_mem_byte_enable;
            rword_q    <= sel_rword;
            if (LATENCY == 1) begin
              // Single-cycle latency: respond straight from the live selection.
              state_q    <= RESP;
              cnt_q      <= 4'd0;
              if_resp_q  <= !sel_mem;
              mem_resp_q <= sel_mem;
              if (!sel_write) begin
                if (sel_mem) mem_rdata_q <= sel_rword;
                else         if_rdata_q  <= sel_rword;
              end
            end else begin
              state_q <= BUSY;
              cnt_q   <= CNT_LOAD;
            end
          end
        end
        BUSY: begin
          cnt_q <= cnt_q - 4'd1;
          if (cnt_q == 4'd1) begin
            state_q    <= RESP;
            if_resp_q  <= !port_mem_q;
            mem_resp_q <= port_mem_q;
            if (!is_write_q) begin
              if (port_mem_q) mem_rdata_q <= rword_q;
              else            if_rdata_q  <= rword_q;
            end
          end
        end
        RESP: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  // Write commit at the edge ending RESP, masked per byte.
  // NOTE: the store array is deliberately not reset so it maps onto RAM and
  // keeps its contents across reset; an aborted access never reaches RESP.
  always_ff @(posedge clk) begin
    if (state_q == RESP && is_write_q) begin
      if (be_q[0]) store[idx_q][7:0]  <= wdata_q[7:0];
      if (be_q[1]) store[idx_q][15:8] <= wdata_q[15:8];
    end
  end

  assign if_mem_resp   = if_resp_q;
  assign mem_mem_resp  = mem_resp_q;
  assign if_mem_rdata  = if_rdata_q;
  assign mem_mem_rdata = mem_rdata_q;

endmodule

// File: tb/tb_lc3b_mem_responder.sv
// Directed bench for lc3b_mem_responder: one instance at the default
// LATENCY=2 and one at LATENCY=1 for the streaming-fetch case.
module tb_lc3b_mem_responder;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // LATENCY = 2 instance
  logic [15:0] if_memaddr = '0;
  logic        if_memread = 1'b0;
  logic [1:0]  if_mem_byte_enable = 2'b11;
  logic        if_mem_resp;
  logic [15:0] if_mem_rdata;
  logic [15:0] mem_memaddr = '0;
  logic        mem_memread = 1'b0;
  logic        mem_memwrite = 1'b0;
  logic [1:0]  mem_mem_byte_enable = 2'b11;
  logic [15:0] mem_mem_wdata = '0;
  logic        mem_mem_resp;
  logic [15:0] mem_mem_rdata;

  // LATENCY = 1 instance
  logic [15:0] d1_if_addr = '0;
  logic        d1_if_read = 1'b0;
  logic        d1_if_resp;
  logic [15:0] d1_if_rdata;
  logic [15:0] d1_mem_addr = '0;
  logic        d1_mem_read = 1'b0;
  logic        d1_mem_write = 1'b0;
  logic [1:0]  d1_mem_be = 2'b11;
  logic [15:0] d1_mem_wdata = '0;
  logic        d1_mem_resp;
  logic [15:0] d1_mem_rdata;

  int n_assert = 0;
  int n_fail   = 0;

  lc3b_mem_responder #(.LATENCY(2), .WORDS_LOG2(8)) dut (
    .clk                 (clk),
    .rst                 (rst),
    .if_memaddr          (if_memaddr),
    .if_memread          (if_memread),
    .if_mem_byte_enable  (if_mem_byte_enable),
    .if_mem_resp         (if_mem_resp),
    .if_mem_rdata        (if_mem_rdata),
    .mem_memaddr         (mem_memaddr),
    .mem_memread         (mem_memread),
    .mem_memwrite        (mem_memwrite),
    .mem_mem_byte_enable (mem_mem_byte_enable),
    .mem_mem_wdata       (mem_mem_wdata),
    .mem_mem_resp        (mem_mem_resp),
    .mem_mem_rdata       (mem_mem_rdata)
  );

  lc3b_mem_responder #(.LATENCY(1), .WORDS_LOG2(8)) dut1 (
    .clk                 (clk),
    .rst                 (rst),
    .if_memaddr          (d1_if_addr),
    .if_memread          (d1_if_read),
    .if_mem_byte_enable  (2'b11),
    .if_mem_resp         (d1_if_resp),
    .if_mem_rdata        (d1_if_rdata),
    .mem_memaddr         (d1_mem_addr),
    .mem_memread         (d1_mem_read),
    .mem_memwrite        (d1_mem_write),
    .mem_mem_byte_enable (d1_mem_be),
    .mem_mem_wdata       (d1_mem_wdata),
    .mem_mem_resp        (d1_mem_resp),
    .mem_mem_rdata       (d1_mem_rdata)
  );

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_assert++;
    assert (got === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // The two response pulses of one instance must never coincide.
  always @(negedge clk) begin
    check("resp_exclusive_l2", 16'(if_mem_resp & mem_mem_resp), 16'h0000);
    check("resp_exclusive_l1", 16'(d1_if_resp & d1_mem_resp), 16'h0000);
  end

  // MEM-port access on the LATENCY=2 instance; lat = cycles from the IDLE
  // cycle in which the request is presented to the cycle showing resp.
  task automatic mem_op(input logic rd, input logic wr, input logic [15:0] a,
                        input logic [15:0] wd, input logic [1:0] be, output int lat);
    @(negedge clk);
    mem_memaddr = a; mem_memread = rd; mem_memwrite = wr;
    mem_mem_wdata = wd; mem_mem_byte_enable = be;
    lat = 0;
    do begin @(negedge clk); lat++; end while (!mem_mem_resp && lat < 20);
    mem_memread = 1'b0; mem_memwrite = 1'b0;
  endtask

  task automatic if_read(input logic [15:0] a, output int lat);
    @(negedge clk);
    if_memaddr = a; if_memread = 1'b1;
    lat = 0;
    do begin @(negedge clk); lat++; end while (!if_mem_resp && lat < 20);
    if_memread = 1'b0;
  endtask

  task automatic d1_write(input logic [15:0] a, input logic [15:0] wd, output int lat);
    @(negedge clk);
    d1_mem_addr = a; d1_mem_write = 1'b1; d1_mem_wdata = wd; d1_mem_be = 2'b11;
    lat = 0;
    do begin @(negedge clk); lat++; end while (!d1_mem_resp && lat < 20);
    d1_mem_write = 1'b0;
  endtask

  initial begin
    int lat, mem_at, if_at, last, k;
    logic [15:0] mrd, ird;

    // Reset state
    repeat (2) @(negedge clk);
    check("reset_if_resp",   16'(if_mem_resp), 16'h0000);
    check("reset_mem_resp",  16'(mem_mem_resp), 16'h0000);
    check("reset_if_rdata",  if_mem_rdata, 16'h0000);
    check("reset_mem_rdata", mem_mem_rdata, 16'h0000);
    rst = 1'b0;

    // Full-word write then IF read back
    mem_op(1'b0, 1'b1, 16'h0010, 16'hBEEF, 2'b11, lat);
    check("wr_beef_latency", 16'(lat), 16'd2);
    if_read(16'h0010, lat);
    check("if_rd_latency", 16'(lat), 16'd2);
    check("if_rd_beef", if_mem_rdata, 16'hBEEF);

    // Low-byte write merges into the existing word
    mem_op(1'b0, 1'b1, 16'h0010, 16'h1234, 2'b01, lat);
    mem_op(1'b1, 1'b0, 16'h0010, 16'h0000, 2'b11, lat);
    check("mem_rd_latency", 16'(lat), 16'd2);
    check("be01_merge", mem_mem_rdata, 16'hBE34);

    // Enables 00: resp still pulses, store unchanged
    mem_op(1'b0, 1'b1, 16'h0010, 16'hFFFF, 2'b00, lat);
    check("be00_resp_latency", 16'(lat), 16'd2);
    mem_op(1'b1, 1'b0, 16'h0010, 16'h0000, 2'b11, lat);
    check("be00_no_change", mem_mem_rdata, 16'hBE34);

    // High-byte write only
    mem_op(1'b0, 1'b1, 16'h0010, 16'h56AB, 2'b10, lat);
    if_read(16'h0010, lat);
    check("be10_merge", if_mem_rdata, 16'h5634);

    // Aliasing: upper address bits and bit 0 are ignored
    if_read(16'h0211, lat);
    check("alias_0211", if_mem_rdata, 16'h5634);
    mem_op(1'b1, 1'b0, 16'h0011, 16'h0000, 2'b11, lat);
    check("alias_0011", mem_mem_rdata, 16'h5634);

    // Read and write together act as a write; MEM rdata keeps its value
    mem_op(1'b1, 1'b1, 16'h0030, 16'h7777, 2'b11, lat);
    check("rw_resp_latency", 16'(lat), 16'd2);
    check("rw_rdata_held", mem_mem_rdata, 16'h5634);
    mem_op(1'b1, 1'b0, 16'h0030, 16'h0000, 2'b11, lat);
    check("rw_was_write", mem_mem_rdata, 16'h7777);

    // Simultaneous requests: MEM first at +2, IF at +5
    @(negedge clk);
    if_memaddr = 16'h0010; if_memread = 1'b1;
    mem_memaddr = 16'h0030; mem_memread = 1'b1;
    mem_at = 0; if_at = 0; mrd = '0; ird = '0;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      if (mem_mem_resp) begin mem_at = c; mem_memread = 1'b0; mrd = mem_mem_rdata; end
      if (if_mem_resp)  begin if_at = c;  if_memread = 1'b0;  ird = if_mem_rdata;  end
    end
    check("arb_mem_cycle", 16'(mem_at), 16'd2);
    check("arb_if_cycle",  16'(if_at),  16'd5);
    check("arb_mem_data", mrd, 16'h7777);
    check("arb_if_data",  ird, 16'h5634);

    // Request changed right after acceptance: captured read completes
    @(negedge clk);
    if_memaddr = 16'h0030; if_memread = 1'b1;
    @(negedge clk);
    if_memaddr = 16'h0010; if_memread = 1'b0;
    lat = 1;
    while (!if_mem_resp && lat < 20) begin @(negedge clk); lat++; end
    check("changed_req_latency", 16'(lat), 16'd2);
    check("changed_req_data", if_mem_rdata, 16'h7777);

    // Reset in the middle of a write aborts it
    mem_op(1'b0, 1'b1, 16'h0020, 16'h5555, 2'b11, lat);
    @(negedge clk);
    mem_memaddr = 16'h0020; mem_memwrite = 1'b1;
    mem_mem_wdata = 16'hAAAA; mem_mem_byte_enable = 2'b11;
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("rst_if_rdata_now",  if_mem_rdata, 16'h0000);
    check("rst_mem_rdata_now", mem_mem_rdata, 16'h0000);
    mem_memwrite = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    k = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (mem_mem_resp || if_mem_resp) k++;
    end
    check("rst_no_resp", 16'(k), 16'd0);
    mem_op(1'b1, 1'b0, 16'h0020, 16'h0000, 2'b11, lat);
    check("rst_write_aborted", mem_mem_rdata, 16'h5555);

    // LATENCY=1 instance: preload, then stream IF reads 0x0000..0x0006
    for (int i = 0; i < 4; i++) begin
      d1_write(16'(2 * i), 16'hC000 + 16'(i), lat);
      check("l1_write_latency", 16'(lat), 16'd1);
    end
    @(negedge clk);
    d1_if_addr = 16'h0000; d1_if_read = 1'b1;
    last = 0; k = 0;
    for (int c = 1; c <= 20 && k < 4; c++) begin
      @(negedge clk);
      if (d1_if_resp) begin
        check("l1_stream_data", d1_if_rdata, 16'hC000 + 16'(k));
        check("l1_stream_gap", 16'(c - last), (k == 0) ? 16'd1 : 16'd2);
        last = c;
        k++;
        d1_if_addr = 16'(2 * k);
        if (k == 4) d1_if_read = 1'b0;
      end
    end
    d1_if_read = 1'b0;
    check("l1_stream_count", 16'(k), 16'd4);

    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
